upsample_stream: RTL

- Parametrised successor to the single-shot fixed-point upsampler.
- Captures a SIZE-element fixed-point vector through a valid/ready handshake.
- Streams SIZE<<log_k interpolated samples, one per cycle, under output backpressure.
- Runtime-selectable ratio (power of two) and mode (nearest-hold or linear). Sits between the softmax/activation vector producers and downstream stream consumers in the accelerator datapath.

---
 rtl/upsample_pkg.sv | 40 ++++
 rtl/upsample_lerp.sv | 50 +++++
 rtl/upsample_stream.sv | 136 +++++++++++++
 3 files changed

// File: rtl/upsample_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : upsample_pkg
//  Purpose  : Shared types, default configuration and width helpers for the
//             streaming fixed-point upsampler.
//  Revision : 1.0 - initial release
// ============================================================================
package upsample_pkg;

   // Two-state controller: waiting for a vector, or streaming it out.
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // Default configuration.
   localparam int unsigned DEF_IL        = 4;
   localparam int unsigned DEF_FL        = 16;
   localparam int unsigned DEF_SIZE      = 4;
   localparam int unsigned DEF_MAX_LOG_K = 3;

   // Width of a counter or selector that must hold values 0..n-1 (at least 1 bit).
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Phase counter width: MAX_LOG_K bits, never zero.
   function automatic int unsigned phase_w(input int unsigned max_log_k);
      return (max_log_k == 0) ? 1 : max_log_k;
   endfunction

   // Widths for the default configuration.
   localparam int unsigned C_W  = DEF_IL + DEF_FL;
   localparam int unsigned C_KW = cnt_w(DEF_MAX_LOG_K + 1);
   localparam int unsigned C_IW = cnt_w(DEF_SIZE);
   localparam int unsigned C_RW = phase_w(DEF_MAX_LOG_K);
   localparam int unsigned C_PW = C_W + 1 + C_RW;

endpackage
`default_nettype wire

// File: rtl/upsample_lerp.sv
`default_nettype none
// ============================================================================
//  Module   : upsample_lerp
//  Purpose  : Combinational sample generator. Returns a (nearest mode) or
//             a + ((r * (b - a)) >>> k) (linear mode), truncated to W bits.
//  Revision : 1.0 - initial release
// ============================================================================
module upsample_lerp #(
   parameter int unsigned W  = 20,
   parameter int unsigned KW = 2,
   parameter int unsigned RW = 3
) (
   input  logic [W-1:0]  a,
   input  logic [W-1:0]  b,
   input  logic [RW-1:0] r,
   input  logic [KW-1:0] k,
   input  logic          mode,
   output logic [W-1:0]  y
);

   localparam int unsigned C_PW = W + 1 + RW;

   logic signed [W:0]      w_diff;
   logic signed [C_PW-1:0] w_diff_x;
   logic signed [C_PW-1:0] w_r_x;
   logic signed [C_PW-1:0] w_prod;
   logic signed [C_PW-1:0] w_shift;
   logic                   w_unused_hi;

   // Difference needs one extra bit; product is wide enough that it never overflows.
   assign w_diff   = $signed({b[W-1], b}) - $signed({a[W-1], a});
   assign w_diff_x = {{RW{w_diff[W]}}, w_diff};
   assign w_r_x    = {{(W+1){1'b0}}, r};
   assign w_prod   = w_diff_x * w_r_x;
   // Arithmetic shift floors toward -infinity.
   assign w_shift  = w_prod >>> k;

   // The interpolated value lies between a and b, so its low W bits are exact.
   assign w_unused_hi = ^w_shift[C_PW-1:W];

   // Select hold or interpolated sample.
   always_comb begin
      y = a;
      if (mode) begin
         y = a + w_shift[W-1:0];
      end
   end

endmodule
`default_nettype wire

// File: rtl/upsample_stream.sv
`default_nettype none
// ============================================================================
//  Module   : upsample_stream
//  Purpose  : Captures a SIZE-element signed fixed-point vector and streams
//             SIZE<<k_eff nearest/linear upsampled samples under backpressure.
//  Revision : 1.0 - initial release
// ============================================================================
module upsample_stream
   import upsample_pkg::*;
#(
   parameter int unsigned IL        = DEF_IL,
   parameter int unsigned FL        = DEF_FL,
   parameter int unsigned SIZE      = DEF_SIZE,
   parameter int unsigned MAX_LOG_K = DEF_MAX_LOG_K
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [IL+FL-1:0]                  im [SIZE],
   input  logic [cnt_w(MAX_LOG_K+1)-1:0]     log_k,
   input  logic                              mode,
   input  logic                              in_valid,
   output logic                              in_ready,
   output logic [IL+FL-1:0]                  out_data,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic                              out_last,
   output logic                              done
);

   localparam int unsigned C_SW  = IL + FL;
   localparam int unsigned C_SKW = cnt_w(MAX_LOG_K + 1);
   localparam int unsigned C_SIW = cnt_w(SIZE);
   localparam int unsigned C_SRW = phase_w(MAX_LOG_K);

   state_e             r_state;
   logic [C_SW-1:0]    r_im [SIZE];
   logic               r_mode;
   logic [C_SKW-1:0]   r_k;
   logic [C_SIW-1:0]   r_seg;
   logic [C_SRW-1:0]   r_ph;
   logic [C_SW-1:0]    r_data;
   logic               r_done;

   logic [31:0]        w_log_k_ext;
   logic [C_SKW-1:0]   w_keff;
   logic [C_SRW-1:0]   w_rmax;
   logic               w_seg_last;
   logic               w_ph_last;
   logic [C_SIW-1:0]   w_nseg;
   logic [C_SRW-1:0]   w_nph;
   logic [C_SIW-1:0]   w_bidx;
   logic [C_SW-1:0]    w_next;

   // Clamp the requested ratio to the largest supported one.
   assign w_log_k_ext = 32'(log_k);
   assign w_keff      = (w_log_k_ext > MAX_LOG_K) ? C_SKW'(MAX_LOG_K) : log_k;

   // Last phase of a segment is (1<<k)-1.
   assign w_rmax     = ~({C_SRW{1'b1}} << r_k);
   assign w_seg_last = (r_seg == C_SIW'(SIZE - 1));
   assign w_ph_last  = (r_ph == w_rmax);

   // Position of the sample that follows the one currently presented.
   assign w_nseg = w_ph_last ? r_seg + C_SIW'(1) : r_seg;
   assign w_nph  = w_ph_last ? '0 : r_ph + C_SRW'(1);
   // The final segment interpolates toward itself, i.e. holds.
   assign w_bidx = (w_nseg == C_SIW'(SIZE - 1)) ? w_nseg : w_nseg + C_SIW'(1);

   upsample_lerp #(
      .W  (C_SW),
      .KW (C_SKW),
      .RW (C_SRW)
   ) u_lerp (
      .a    (r_im[w_nseg]),
      .b    (r_im[w_bidx]),
      .r    (w_nph),
      .k    (r_k),
      .mode (r_mode),
      .y    (w_next)
   );

   // Vector capture register; contents are only meaningful while streaming.
   always_ff @(posedge clk) begin
      if (!rst && (r_state == IDLE) && in_valid) begin
         r_im <= im;
      end
   end

   // Controller: capture, advance on each output handshake, finish with a done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_mode  <= 1'b0;
         r_k     <= '0;
         r_seg   <= '0;
         r_ph    <= '0;
         r_data  <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_mode  <= mode;
                  r_k     <= w_keff;
                  r_seg   <= '0;
                  r_ph    <= '0;
                  r_data  <= im[0];
                  r_state <= RUN;
               end
            end
            RUN: begin
               if (out_ready) begin
                  if (w_seg_last && w_ph_last) begin
                     r_state <= IDLE;
                     r_done  <= 1'b1;
                  end else begin
                     r_seg  <= w_nseg;
                     r_ph   <= w_nph;
                     r_data <= w_next;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE) && !rst;
   assign out_valid = (r_state == RUN);
   assign out_last  = (r_state == RUN) && w_seg_last && w_ph_last;
   assign out_data  = r_data;
   assign done      = r_done;

endmodule
`default_nettype wire
